// File: rtl/param_slow_divider.sv
// param_slow_divider: multi-cycle restoring/non-restoring integer divider, one quotient bit per clock
module param_slow_divider #(
    parameter int N_WIDTH   = 8,
    parameter int D_WIDTH   = 4,
    parameter int MODE      = 0,
    parameter int SIGNED_EN = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n_in,
    input  logic [D_WIDTH-1:0] d_in,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] q_out,
    output logic [D_WIDTH-1:0] r_out,
    output logic               dbz,
    output logic               ovf
);
    localparam int CW = $clog2(N_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [N_WIDTH-1:0] acc, n_mag, q_fin;
    logic [D_WIDTH-1:0] dv, d_mag, r_fin;
    logic [D_WIDTH:0]   pr, r_fix;
    logic [D_WIDTH+1:0] shs, sub, add, nxt;
    logic [CW-1:0]      cnt;
    logic               n_neg, d_neg, ovf_c, n_neg_in, d_neg_in, is_ovf, q_bit;
    // Operand conditioning, one iteration of the division step, and the final sign/remainder fix-up
    always_comb begin
        n_neg_in = (SIGNED_EN != 0) && n_in[N_WIDTH-1];
        d_neg_in = (SIGNED_EN != 0) && d_in[D_WIDTH-1];
        n_mag    = n_neg_in ? -n_in : n_in;
        d_mag    = d_neg_in ? -d_in : d_in;
        is_ovf   = (SIGNED_EN != 0) && n_in == {1'b1, {(N_WIDTH-1){1'b0}}} && d_in == '1;
        shs      = {pr, acc[N_WIDTH-1]};
        sub      = shs - {2'b00, dv};
        add      = shs + {2'b00, dv};
        nxt      = (MODE != 0) ? (pr[D_WIDTH] ? add : sub) : (sub[D_WIDTH+1] ? shs : sub);
        q_bit    = (MODE != 0) ? ~nxt[D_WIDTH+1] : ~sub[D_WIDTH+1];
        r_fix    = (MODE != 0 && pr[D_WIDTH]) ? pr + {1'b0, dv} : pr;
        q_fin    = (n_neg ^ d_neg) ? -acc : acc;
        r_fin    = n_neg ? -r_fix[D_WIDTH-1:0] : r_fix[D_WIDTH-1:0];
    end
    // Next-state selection; a zero divisor skips straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (d_in == '0) ? DONE : RUN;
            RUN:     if (cnt == CW'(N_WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // Datapath: capture operands, shift quotient bits into the dividend register, load results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            dv    <= '0;
            pr    <= '0;
            cnt   <= '0;
            n_neg <= 1'b0;
            d_neg <= 1'b0;
            ovf_c <= 1'b0;
            q_out <= '0;
            r_out <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= n_mag;
                    dv    <= d_mag;
                    pr    <= '0;
                    cnt   <= '0;
                    n_neg <= n_neg_in;
                    d_neg <= d_neg_in;
                    ovf_c <= is_ovf;
                    if (d_in == '0) begin
                        q_out <= '1;
                        r_out <= n_in[D_WIDTH-1:0];
                        dbz   <= 1'b1;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= {acc[N_WIDTH-2:0], q_bit};
                    pr  <= nxt[D_WIDTH:0];
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    q_out <= q_fin;
                    r_out <= r_fin;
                    dbz   <= 1'b0;
                    ovf   <= ovf_c;
                end
                default: ;
            endcase
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_param_slow_divider.sv
// tb_param_slow_divider: four divider configurations driven in lockstep against an arithmetic reference model
module tb_param_slow_divider;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] n_in = '0;
    logic [3:0] d_in = '0;
    logic       busy_w[4], done_w[4], dbz_w[4], ovf_w[4];
    logic [7:0] q_w[4];
    logic [3:0] r_w[4];
    int         n_chk = 0, n_fail = 0;
    bit         m_busy = 0;
    int         m_age = 0, m_lat = 0, cyc;
    logic [13:0] pend[4], held[4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        param_slow_divider #(.N_WIDTH(8), .D_WIDTH(4), .MODE(g % 2), .SIGNED_EN(g / 2)) u (
            .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in),
            .busy(busy_w[g]), .done(done_w[g]), .q_out(q_w[g]), .r_out(r_w[g]),
            .dbz(dbz_w[g]), .ovf(ovf_w[g])
        );
    end

    // Reference result packed as {ovf, dbz, r[3:0], q[7:0]}
    function automatic logic [13:0] ref_div(input logic [7:0] n, input logic [3:0] d, input bit sg);
        int sn, sd, q, r;
        if (d == 0) return {1'b0, 1'b1, n[3:0], 8'hFF};
        sn = sg ? int'($signed(n)) : int'(n);
        sd = sg ? int'($signed(d)) : int'(d);
        if (sg && sn == -128 && sd == -1) return {1'b1, 1'b0, 4'h0, 8'h80};
        q = sn / sd;
        r = sn % sd;
        return {2'b00, r[3:0], q[7:0]};
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, g, a, e, $time);
        end
    endtask

    // Transaction-level model: accepts a start when idle, finishes after the fixed latency
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0;
            for (int g = 0; g < 4; g++) held[g] = '0;
        end else if (m_busy) begin
            if (m_age == m_lat) begin
                m_busy = 0;
                for (int g = 0; g < 4; g++) held[g] = pend[g];
            end else m_age++;
        end else if (start) begin
            m_busy = 1;
            m_age  = 1;
            m_lat  = (d_in == 0) ? 1 : 10;
            for (int g = 0; g < 4; g++) pend[g] = ref_div(n_in, d_in, g >= 2);
        end
    end

    // Every cycle, every configuration must match the model
    always @(negedge clk) begin
        logic        ed;
        logic [13:0] e;
        ed = m_busy && m_age == m_lat;
        for (int g = 0; g < 4; g++) begin
            e = ed ? pend[g] : held[g];
            chk("busy", g, 32'(busy_w[g]), 32'(m_busy));
            chk("done", g, 32'(done_w[g]), 32'(ed));
            chk("q", g, 32'(q_w[g]), 32'(e[7:0]));
            chk("r", g, 32'(r_w[g]), 32'(e[11:8]));
            chk("dbz", g, 32'(dbz_w[g]), 32'(e[12]));
            chk("ovf", g, 32'(ovf_w[g]), 32'(e[13]));
        end
    end

    task automatic wait_done(output int c);
        bit got = 0;
        c = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            got = done_w[0];
            #1 start = 1'b0;
        end
        chk("timeout", 0, 32'(got), 1);
    endtask

    task automatic go(input logic [7:0] n, input logic [3:0] d, output int c);
        @(negedge clk);
        #1 n_in = n; d_in = d; start = 1'b1;
        wait_done(c);
    endtask

    initial begin
        logic [11:0] vec[8] = '{{8'd0, 4'd3}, {8'd255, 4'd1}, {8'd127, 4'd8},
                                {8'd128, 4'd15}, {8'd1, 4'd14}, {8'd99, 4'd9},
                                {8'd250, 4'd12}, {8'd64, 4'd7}};
        repeat (2) @(negedge clk);
        chk("rst_q", 0, 32'(q_w[0]), 0);
        chk("rst_busy", 0, 32'(busy_w[0]), 0);
        #1 reset = 1'b0;
        go(8'd27, 4'd5, cyc);
        chk("lat27", 0, cyc, 10);
        chk("q27", 0, 32'(q_w[0]), 5);
        chk("r27", 0, 32'(r_w[0]), 2);
        chk("dbz27", 0, 32'(dbz_w[0]), 0);
        go(8'd255, 4'd15, cyc);
        chk("lat255", 1, cyc, 10);
        chk("q255", 1, 32'(q_w[1]), 17);
        chk("r255", 1, 32'(r_w[1]), 0);
        go(8'd200, 4'd7, cyc);
        chk("q200", 1, 32'(q_w[1]), 28);
        chk("r200", 1, 32'(r_w[1]), 4);
        go(8'hF9, 4'd2, cyc);
        chk("qs1", 2, 32'(q_w[2]), 32'h FD);
        chk("rs1", 3, 32'(r_w[3]), 32'h F);
        go(8'd7, 4'hE, cyc);
        chk("qs2", 3, 32'(q_w[3]), 32'h FD);
        chk("rs2", 2, 32'(r_w[2]), 1);
        go(8'h80, 4'hF, cyc);
        chk("qovf", 2, 32'(q_w[2]), 32'h80);
        chk("ovf", 3, 32'(ovf_w[3]), 1);
        chk("ovf_u", 0, 32'(ovf_w[0]), 0);
        go(8'd100, 4'd0, cyc);
        chk("lat_dbz", 0, cyc, 1);
        chk("q_dbz", 0, 32'(q_w[0]), 255);
        chk("r_dbz", 0, 32'(r_w[0]), 4);
        chk("dbz", 1, 32'(dbz_w[1]), 1);
        @(negedge clk);
        #1 n_in = 8'd27; d_in = 4'd5; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        #1 n_in = 8'd99; d_in = 4'd7; start = 1'b1;
        wait_done(cyc);
        chk("q_ign", 0, 32'(q_w[0]), 5);
        chk("r_ign", 1, 32'(r_w[1]), 2);
        @(negedge clk);
        #1 n_in = 8'd200; d_in = 4'd7; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_q", 0, 32'(q_w[0]), 0);
        chk("rst_mid_done", 0, 32'(done_w[0]), 0);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        go(8'd9, 4'd3, cyc);
        chk("lat9", 0, cyc, 10);
        chk("q9", 0, 32'(q_w[0]), 3);
        chk("r9", 0, 32'(r_w[0]), 0);
        foreach (vec[i]) go(vec[i][11:4], vec[i][3:0], cyc);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/param_slow_divider.md
PARAM_SLOW_DIVIDER -- requirements
Module: param_slow_divider

Interface
REQ-001 The block SHALL have these parameters, one per line:
- N_WIDTH, default 8, dividend and quotient width (>=2).
- D_WIDTH, default 4, divisor and remainder width (>=2, <=N_WIDTH).
- MODE, default 0; 0 = restoring, 1 = non-restoring.
- SIGNED_EN, default 0; 1 = two's-complement operands and results.

REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  clock; all flops on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- n_in  in  N_WIDTH  dividend.
- d_in  in  D_WIDTH  divisor.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; results valid.
- q_out  out  N_WIDTH  quotient.
- r_out  out  D_WIDTH  remainder.
- dbz  out  1  divide-by-zero flag, valid with done.
- ovf  out  1  signed overflow flag, valid with done.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-004 In IDLE with start=1, the block SHALL capture n_in and d_in internally, convert them to magnitudes when SIGNED_EN=1, and record both signs.
- If d_in is non-zero, it goes to RUN with the bit counter at 0.
- If d_in is zero, it goes to DONE.
REQ-005 In RUN, the block SHALL resolve exactly one quotient bit per clock, MSB first, using a (D_WIDTH+1)-bit partial remainder.
REQ-006 MODE=0 (restoring): each cycle, shift in the next dividend bit and subtract the divisor; if the result is negative, keep the pre-subtract value and set q bit 0; otherwise keep the result and set q bit 1.
REQ-007 MODE=1 (non-restoring): each cycle, shift in the next dividend bit, then subtract the divisor if the partial remainder is >=0 or add it if <0; the q bit is 1 when the new remainder is >=0.
REQ-008 After N_WIDTH RUN cycles, the block SHALL go to FIX.
REQ-009 In FIX, the block SHALL:
- for MODE=1 only, add the divisor once if the remainder is negative;
- when SIGNED_EN=1, negate q if the operand signs differ and negate r if the dividend was negative (truncating division).
REQ-010 In DONE, the block SHALL register q_out, r_out, dbz and ovf, pulse done high for exactly one cycle, and return to IDLE.
REQ-011 Latency SHALL be:
- d non-zero: done high in cycle N_WIDTH+2 after the edge that sampled start.
- d = 0: done high in cycle 1 after that edge.
- Both values are identical for both MODE settings.
REQ-012 On divide-by-zero, the block SHALL output q_out = all ones, r_out = the low D_WIDTH bits of n_in, dbz=1 and ovf=0.
REQ-013 When SIGNED_EN=1, n_in = -2^(N_WIDTH-1) and d_in = -1, the block SHALL output q_out = -2^(N_WIDTH-1) (wrapped), r_out = 0 and ovf=1; otherwise ovf=0.
REQ-014 The block SHALL ignore start while busy=1; captured operands SHALL NOT change until the next IDLE.
REQ-015 The block SHALL accept a start in the IDLE cycle that directly follows DONE, giving back-to-back operation with one idle cycle.
REQ-016 The block SHALL hold q_out, r_out, dbz and ovf stable from done until the next DONE state.

Reset
REQ-017 Asserting reset SHALL immediately set:
- state = IDLE, busy=0, done=0;
- q_out=0, r_out=0, dbz=0, ovf=0;
- all internal registers to 0.
REQ-018 Reset asserted mid-operation SHALL abort the division with no done pulse; the next start after release SHALL operate normally.

Verification
REQ-019 With defaults N=8, D=4, MODE=0, unsigned, the bench SHALL cover at least these scenarios:
- n=27, d=5 -> done in cycle 10 after the start edge, q=5, r=2, dbz=0.
- MODE=1, n=255, d=15 -> q=17, r=0; n=200, d=7 -> q=28, r=4; latency identical to MODE=0.
- SIGNED_EN=1: n=-7, d=2 -> q=-3, r=-1; n=7, d=-2 -> q=-3, r=1; n=-128, d=-1 -> q=-128, ovf=1.
- n=100, d=0 -> done in cycle 1, q=255, r=4, dbz=1.
- start pulsed again at RUN cycle 3 with new operands -> ignored, first result unchanged.
- reset at RUN cycle 4 -> no done, all outputs 0; new start n=9, d=3 -> q=3, r=0.
